// File: rtl/id_hazard_scoreboard.sv
// Register scoreboard and issue gate beside decode: tracks in-flight GPR/FPR writes.
// Latency: issue_ok/stall are combinational; pending/inflight/error update on the next edge.
// Backpressure: stall holds decode on RAW, WAW or a full writer count; nothing is queued.
module id_hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        rs_used,
    input  logic        rt_used,
    input  logic        src_fp,
    input  logic        dst_wr,
    input  logic        dst_fp,
    input  logic [4:0]  dst,
    input  logic        wb_valid,
    input  logic        wb_fp,
    input  logic [4:0]  wb_reg,
    output logic        issue_ok,
    output logic        stall,
    output logic [3:0]  inflight,
    output logic [31:0] gpr_pending,
    output logic [31:0] fpr_pending,
    output logic        error
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    logic [31:0] gpr_pending_q, gpr_pending_d;
    logic [31:0] fpr_pending_q, fpr_pending_d;
    logic [3:0]  inflight_q, inflight_d;
    logic        error_q, error_d;

    logic [31:0] src_pend;
    logic [31:0] dst_pend;
    logic [31:0] wb_pend;
    logic        raw_hit;
    logic        waw_hit;
    logic        counts;
    logic        full_hit;
    logic        issue_ok_c;
    logic        accept;
    logic        retire_req;
    logic        retire_good;
    logic        retire_bad;

    // Hazard detection against registered pending bits; no same-cycle writeback bypass.
    always_comb begin
        src_pend    = src_fp ? fpr_pending_q : gpr_pending_q;
        dst_pend    = dst_fp ? fpr_pending_q : gpr_pending_q;
        wb_pend     = wb_fp  ? fpr_pending_q : gpr_pending_q;

        raw_hit     = (rs_used & src_pend[rs]) | (rt_used & src_pend[rt]);
        waw_hit     = dst_wr & dst_pend[dst];
        // GPR 0 writes are discarded by the register file, so they hold no slot.
        counts      = dst_wr & (dst_fp | (dst != 5'd0));
        full_hit    = counts & (inflight_q == MAX_CNT);

        issue_ok_c  = issue_valid & ~raw_hit & ~waw_hit & ~full_hit;
        accept      = issue_ok_c & counts;

        retire_req  = wb_valid & (wb_fp | (wb_reg != 5'd0));
        retire_bad  = retire_req & (~wb_pend[wb_reg] | (inflight_q == 4'd0));
        retire_good = retire_req & ~retire_bad;
    end

    // Next-state: clear on good retire, set on accept, net counter change, sticky error.
    always_comb begin
        gpr_pending_d = gpr_pending_q;
        fpr_pending_d = fpr_pending_q;
        inflight_d    = inflight_q;
        error_d       = error_q;

        if (retire_good) begin
            if (wb_fp) begin
                fpr_pending_d[wb_reg] = 1'b0;
            end else begin
                gpr_pending_d[wb_reg] = 1'b0;
            end
        end

        // Same-register accept+retire cannot both be good (WAW), so order is harmless.
        if (accept) begin
            if (dst_fp) begin
                fpr_pending_d[dst] = 1'b1;
            end else begin
                gpr_pending_d[dst] = 1'b1;
            end
        end

        case ({accept, retire_good})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase

        if (retire_bad) begin
            error_d = 1'b1;
        end
    end

    // State registers; asynchronous reset drops every in-flight record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpr_pending_q <= '0;
            fpr_pending_q <= '0;
            inflight_q    <= '0;
            error_q       <= 1'b0;
        end else begin
            gpr_pending_q <= gpr_pending_d;
            fpr_pending_q <= fpr_pending_d;
            inflight_q    <= inflight_d;
            error_q       <= error_d;
        end
    end

    assign issue_ok    = issue_ok_c;
    assign stall       = issue_valid & ~issue_ok_c;
    assign inflight    = inflight_q;
    assign gpr_pending = gpr_pending_q;
    assign fpr_pending = fpr_pending_q;
    assign error       = error_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  rs, rt, dst, wb_reg;
    logic        rs_used, rt_used, src_fp, dst_wr, dst_fp, wb_valid, wb_fp;
    logic        issue_ok, stall, error;
    logic [3:0]  inflight;
    logic [31:0] gpr_pending, fpr_pending;

    id_hazard_scoreboard #(.MAX_INFLIGHT(4)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used), .src_fp(src_fp),
        .dst_wr(dst_wr), .dst_fp(dst_fp), .dst(dst),
        .wb_valid(wb_valid), .wb_fp(wb_fp), .wb_reg(wb_reg),
        .issue_ok(issue_ok), .stall(stall), .inflight(inflight),
        .gpr_pending(gpr_pending), .fpr_pending(fpr_pending), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs;
        logic        rsu;
        logic [4:0]  rt;
        logic        rtu;
        logic        sfp;
        logic        dw;
        logic        dfp;
        logic [4:0]  dst;
        logic        wbv;
        logic        wbfp;
        logic [4:0]  wbr;
        logic        ok;
        logic [3:0]  inf;
        logic [31:0] gpr;
        logic [31:0] fpr;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0]  inf;
        logic [31:0] gpr;
        logic [31:0] fpr;
        logic        err;
    } post_t;

    vec_t  vecs[$];
    post_t sb[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;

    function automatic vec_t mk(logic iv, logic [4:0] rs_i, logic rsu, logic [4:0] rt_i, logic rtu,
                                logic sfp, logic dw, logic dfp, logic [4:0] dst_i,
                                logic wbv, logic wbfp, logic [4:0] wbr,
                                logic ok, logic [3:0] inf, logic [31:0] g, logic [31:0] f, logic err);
        vec_t v;
        v.iv = iv; v.rs = rs_i; v.rsu = rsu; v.rt = rt_i; v.rtu = rtu; v.sfp = sfp;
        v.dw = dw; v.dfp = dfp; v.dst = dst_i; v.wbv = wbv; v.wbfp = wbfp; v.wbr = wbr;
        v.ok = ok; v.inf = inf; v.gpr = g; v.fpr = f; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_idle();
        issue_valid = 0; rs = 0; rt = 0; rs_used = 0; rt_used = 0; src_fp = 0;
        dst_wr = 0; dst_fp = 0; dst = 0; wb_valid = 0; wb_fp = 0; wb_reg = 0;
    endtask

    // Called just after a falling edge: drive, check combinational gate, queue the post-edge state.
    task automatic apply(input int idx, input vec_t v);
        post_t p, got;
        issue_valid = v.iv; rs = v.rs; rs_used = v.rsu; rt = v.rt; rt_used = v.rtu;
        src_fp = v.sfp; dst_wr = v.dw; dst_fp = v.dfp; dst = v.dst;
        wb_valid = v.wbv; wb_fp = v.wbfp; wb_reg = v.wbr;
        p.inf = v.inf; p.gpr = v.gpr; p.fpr = v.fpr; p.err = v.err;
        sb.push_back(p);
        #1;
        chk($sformatf("v%0d issue_ok", idx), {31'd0, issue_ok}, {31'd0, v.ok});
        chk($sformatf("v%0d stall", idx), {31'd0, stall}, {31'd0, v.iv & ~v.ok});
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("v%0d inflight", idx), {28'd0, inflight}, {28'd0, got.inf});
        chk($sformatf("v%0d gpr_pending", idx), gpr_pending, got.gpr);
        chk($sformatf("v%0d fpr_pending", idx), fpr_pending, got.fpr);
        chk($sformatf("v%0d error", idx), {31'd0, error}, {31'd0, got.err});
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst inflight", {28'd0, inflight}, 32'd0);
        chk("rst gpr", gpr_pending, 32'd0);
        chk("rst fpr", fpr_pending, 32'd0);
        chk("rst error", {31'd0, error}, 32'd0);
        chk("rst ok idle", {31'd0, issue_ok}, 32'd0);
        issue_valid = 1'b1;
        #1;
        chk("rst ok follows valid", {31'd0, issue_ok}, 32'd1);
        chk("rst stall", {31'd0, stall}, 32'd0);
        drive_idle();
        @(negedge clk);

        //        iv rs  rsu rt  rtu sfp dw dfp dst wbv wbf wbr  ok inf gpr           fpr         err
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 1, 1, 32'h0000_0020, 32'h0, 0)); // writer G5
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 32'h0000_0000, 32'h0, 0)); // RAW, retire same cycle
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0000, 32'h0, 0)); // unblocked next cycle
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0000, 32'h0, 0)); // G0 write ignored
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 32'h0000_0000, 32'h1, 0)); // F0 counts
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0000_0000, 32'h0, 0)); // retire F0
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 32'h0000_0002, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 2, 32'h0000_0006, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 3, 32'h0000_000E, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 1, 4, 32'h0000_001E, 32'h0, 0)); // full
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 4, 32'h0000_001E, 32'h0, 0)); // full stall
        vecs.push_back(mk(1,10, 1,11, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h0000_001E, 32'h0, 0)); // non-writer passes
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 6, 1, 0, 2, 0, 3, 32'h0000_001A, 32'h0, 0)); // retire no same-cycle free
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0, 0, 1, 4, 32'h0000_005A, 32'h0, 0)); // G6 accepted
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3, 32'h0000_0058, 32'h0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 2, 32'h0000_0048, 32'h0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 1, 32'h0000_0008, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 1, 2, 32'h0000_0088, 32'h0, 0)); // writer G7
        vecs.push_back(mk(1, 7, 1, 0, 0, 1, 1, 1, 7, 0, 0, 0, 1, 3, 32'h0000_0088, 32'h80, 0)); // F7 independent
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 3, 32'h0000_0088, 32'h80, 0)); // WAW G7
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 9, 1, 0, 3, 1, 3, 32'h0000_0280, 32'h80, 0)); // accept+retire
        vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h0000_0280, 32'h80, 0)); // RAW via rt
        vecs.push_back(mk(1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h0000_0280, 32'h80, 0)); // unused sources
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,12, 0, 3, 32'h0000_0280, 32'h80, 1)); // bad retire
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h0000_0280, 32'h80, 1)); // sticky

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Asynchronous reset between edges with inflight=3.
        chk("pre-reset inflight", {28'd0, inflight}, 32'd3);
        issue_valid = 1'b1; dst_wr = 1'b1; dst = 5'd7;
        #2;
        reset = 1'b1;
        #1;
        chk("async rst inflight", {28'd0, inflight}, 32'd0);
        chk("async rst gpr", gpr_pending, 32'd0);
        chk("async rst fpr", fpr_pending, 32'd0);
        chk("async rst error", {31'd0, error}, 32'd0);
        chk("async rst ok", {31'd0, issue_ok}, 32'd1);
        chk("async rst stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
